pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces fixed-field latches such as the decode/execute register with one generic block, instantiated once per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data payload and a control word under a valid/ready handshake. It supports back-pressure (stall), synchronous flush (squash), and zeroes the control word on bubbles so squashed instructions never write the register file or memory. An optional skid entry keeps `in_ready_o` registered, off the downstream combinational path.

---
 rtl/pipe_stage_reg_pkg.sv | 24 ++
 rtl/pipe_stage_reg_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 173 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and types for the inter-stage pipeline registers.
package pipe_pkg;

    // ID/EX boundary widths: payload is inst, pc, rs data, rt data, imm (5 x 32).
    localparam int IDEX_DATA_W = 160;
    localparam int IDEX_CTRL_W = 7;

    // Bit offsets inside the ID/EX control word.
    localparam int CTRL_MEMWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP    = 4;  // ALUOp occupies bits 4..5
    localparam int CTRL_ALUOP_W  = 2;
    localparam int CTRL_REGDST   = 6;

    // Occupancy of a stage register; the encoding equals the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline entry: valid bit plus payload and control word.
// clear drops the valid bit but keeps data/ctrl; load writes a live entry.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    // Entry register: reset zeroes everything, clear only kills the valid bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            ctrl_o  <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            ctrl_o  <= ctrl_i;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, flush and bubble masking.
// With SKID=1 a second entry absorbs the one extra instruction that arrives
// while the downstream stalls, so in_ready_o can come straight from a flop.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and payload stable until the transfer;
// ready may rise or fall freely and never depends on the same-side valid.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        count_o
);

    occ_e              occState;
    occ_e              occNext;
    logic              accept;
    logic              drain;
    logic              inReadyQ;
    logic [1:0]        countQ;

    logic              mValid;
    logic [DATA_W-1:0] mData;
    logic [CTRL_W-1:0] mCtrl;
    logic              mLoad;
    logic              mClear;
    logic              mFromSkid;
    logic [DATA_W-1:0] mDataNext;
    logic [CTRL_W-1:0] mCtrlNext;

    logic              sValid;
    logic [DATA_W-1:0] sData;
    logic [CTRL_W-1:0] sCtrl;
    logic              sLoad;
    logic              sClear;

    assign in_ready_o = (SKID != 0) ? inReadyQ : (!mValid || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign drain      = mValid && out_ready_i;

    // Next occupancy and slot load/clear strobes; flush overrides any handshake.
    always_comb begin
        occNext   = occState;
        mLoad     = 1'b0;
        mClear    = 1'b0;
        mFromSkid = 1'b0;
        sLoad     = 1'b0;
        sClear    = 1'b0;
        if (flush_i) begin
            mClear  = 1'b1;
            sClear  = 1'b1;
            occNext = EMPTY;
        end else if (SKID != 0) begin
            unique case (occState)
                EMPTY: begin
                    if (accept) begin
                        mLoad   = 1'b1;
                        occNext = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        mLoad = 1'b1;
                    end else if (accept) begin
                        sLoad   = 1'b1;
                        occNext = FULL;
                    end else if (drain) begin
                        mClear  = 1'b1;
                        occNext = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        mLoad     = 1'b1;
                        mFromSkid = 1'b1;
                        sClear    = 1'b1;
                        occNext   = ONE;
                    end
                end
                default: begin
                    mClear  = 1'b1;
                    sClear  = 1'b1;
                    occNext = EMPTY;
                end
            endcase
        end else begin
            if (accept) begin
                mLoad   = 1'b1;
                occNext = ONE;
            end else if (drain) begin
                mClear  = 1'b1;
                occNext = EMPTY;
            end
        end
    end

    // Occupancy state, registered count and registered ready all move together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occState <= EMPTY;
            countQ   <= 2'd0;
            inReadyQ <= 1'b1;
        end else begin
            occState <= occNext;
            countQ   <= occNext;
            inReadyQ <= (occNext != FULL);
        end
    end

    assign mDataNext = mFromSkid ? sData : in_data_i;
    assign mCtrlNext = mFromSkid ? sCtrl : in_ctrl_i;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) uMain (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (mClear),
        .load_i  (mLoad),
        .data_i  (mDataNext),
        .ctrl_i  (mCtrlNext),
        .valid_o (mValid),
        .data_o  (mData),
        .ctrl_o  (mCtrl)
    );

    generate
        if (SKID != 0) begin : gSkid
            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) uSkid (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clear_i (sClear),
                .load_i  (sLoad),
                .data_i  (in_data_i),
                .ctrl_i  (in_ctrl_i),
                .valid_o (sValid),
                .data_o  (sData),
                .ctrl_o  (sCtrl)
            );
        end else begin : gNoSkid
            logic unusedSkidStrobes;
            assign sValid            = 1'b0;
            assign sData             = '0;
            assign sCtrl             = '0;
            assign unusedSkidStrobes = sLoad ^ sClear ^ sValid;
        end
    endgenerate

    assign out_valid_o = mValid;
    assign out_data_o  = mData;
    // Bubbles carry an all-zero control word so they never write anything.
    assign out_ctrl_o  = mValid ? mCtrl : '0;
    assign count_o     = countQ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 instance under a scoreboard and one
// SKID=0 instance for the combinational-ready path.
module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam int CW = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          inValid, inReady, outValid, outReady;
    logic [DW-1:0] inData, outData;
    logic [CW-1:0] inCtrl, outCtrl;
    logic [1:0]    count;

    logic          flush0;
    logic          inValid0, inReady0, outValid0, outReady0;
    logic [DW-1:0] inData0, outData0;
    logic [CW-1:0] inCtrl0, outCtrl0;
    logic [1:0]    count0;

    int passCnt  = 0;
    int checkCnt = 0;

    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] expc_q[$];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_data_i   (inData),
        .in_ctrl_i   (inCtrl),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_data_o  (outData),
        .out_ctrl_o  (outCtrl),
        .count_o     (count)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush0),
        .in_valid_i  (inValid0),
        .in_ready_o  (inReady0),
        .in_data_i   (inData0),
        .in_ctrl_i   (inCtrl0),
        .out_valid_o (outValid0),
        .out_ready_i (outReady0),
        .out_data_o  (outData0),
        .out_ctrl_o  (outCtrl0),
        .count_o     (count0)
    );

    // ---------------- driver / scoreboard ----------------
    // Called at a negedge with inputs already driven: scores this cycle's
    // transfers, then advances to the next negedge.
    task automatic step();
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        #1;
        if (flush) begin
            exp_q.delete();
            expc_q.delete();
        end else begin
            if (outValid && outReady) begin
                checkCnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_spurious: got data %h, expected no output", outData);
                end else begin
                    ed = exp_q.pop_front();
                    ec = expc_q.pop_front();
                    if (outData !== ed || outCtrl !== ec)
                        $display("FAIL sb_order: got %h/%h expected %h/%h", outData, outCtrl, ed, ec);
                    else
                        passCnt++;
                end
            end
            if (inValid && inReady) begin
                exp_q.push_back(inData);
                expc_q.push_back(inCtrl);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic r);
        inValid  = v;
        inData   = d;
        inCtrl   = c;
        outReady = r;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; flush0 = 1'b0;
        drive(1'b1, 160'hAA, 7'h7F, 1'b0);
        inValid0 = 1'b1; inData0 = 160'hAA; inCtrl0 = 7'h7F; outReady0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkCnt++; if (outValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", outValid); else passCnt++;
        checkCnt++; if (outCtrl !== 7'h0) $display("FAIL reset_ctrl: got %h expected 0", outCtrl); else passCnt++;
        checkCnt++; if (outData !== 160'h0) $display("FAIL reset_data: got %h expected 0", outData); else passCnt++;
        checkCnt++; if (count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", count); else passCnt++;
        checkCnt++; if (inReady !== 1'b1) $display("FAIL reset_ready: got %b expected 1", inReady); else passCnt++;
        checkCnt++; if (outValid0 !== 1'b0 || inReady0 !== 1'b1)
            $display("FAIL reset_skid0: got valid %b ready %b expected 0/1", outValid0, inReady0); else passCnt++;
        rst = 1'b0;
        inValid = 1'b0;
        inValid0 = 1'b0;
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [3];
        vals[0] = 160'h11; vals[1] = 160'h22; vals[2] = 160'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 7'h7F, 1'b1);
            step();
            checkCnt++;
            if (outValid !== 1'b1 || outData !== vals[i] || count !== 2'd1)
                $display("FAIL stream_%0d: got v%b d%h c%0d expected v1 d%h c1", i, outValid, outData, count, vals[i]);
            else passCnt++;
        end
        drive(1'b0, 160'h0, 7'h0, 1'b1);
        step();
        checkCnt++; if (count !== 2'd0 || outValid !== 1'b0)
            $display("FAIL stream_end: got count %0d valid %b expected 0/0", count, outValid); else passCnt++;
    endtask

    task automatic test_stall_fill();
        drive(1'b1, 160'hA1, 7'h15, 1'b0); step();
        drive(1'b1, 160'hB2, 7'h2A, 1'b0); step();
        checkCnt++; if (count !== 2'd2) $display("FAIL fill_count: got %0d expected 2", count); else passCnt++;
        checkCnt++; if (inReady !== 1'b0) $display("FAIL fill_ready: got %b expected 0", inReady); else passCnt++;
        checkCnt++; if (outData !== 160'hA1 || outCtrl !== 7'h15)
            $display("FAIL fill_head: got %h/%h expected a1/15", outData, outCtrl); else passCnt++;
        // offered while full: must be refused, and the head must hold still
        drive(1'b1, 160'hD4, 7'h01, 1'b0); step();
        checkCnt++; if (outData !== 160'hA1 || outCtrl !== 7'h15 || count !== 2'd2)
            $display("FAIL stall_hold: got %h/%h c%0d expected a1/15 c2", outData, outCtrl, count); else passCnt++;
        drive(1'b0, 160'h0, 7'h0, 1'b1); step();
        checkCnt++; if (outData !== 160'hB2 || outValid !== 1'b1 || count !== 2'd1)
            $display("FAIL release_b: got %h v%b c%0d expected b2 v1 c1", outData, outValid, count); else passCnt++;
        step();
        checkCnt++; if (exp_q.size() != 0 || count !== 2'd0 || outValid !== 1'b0)
            $display("FAIL release_done: got q%0d c%0d v%b expected 0/0/0", exp_q.size(), count, outValid); else passCnt++;
    endtask

    task automatic test_flush();
        drive(1'b1, 160'hA5, 7'h11, 1'b0); step();
        drive(1'b1, 160'hB6, 7'h22, 1'b0); step();
        flush = 1'b1;
        drive(1'b1, 160'hC7, 7'h7F, 1'b0); step();
        flush = 1'b0;
        checkCnt++; if (outValid !== 1'b0 || outCtrl !== 7'h0 || count !== 2'd0 || inReady !== 1'b1)
            $display("FAIL flush_state: got v%b ctrl%h c%0d r%b expected 0/0/0/1", outValid, outCtrl, count, inReady); else passCnt++;
        checkCnt++; if (outData !== 160'hA5)
            $display("FAIL flush_keep_data: got %h expected a5", outData); else passCnt++;
        drive(1'b0, 160'h0, 7'h7F, 1'b1);
        repeat (3) step();
        checkCnt++; if (outValid !== 1'b0) $display("FAIL flush_no_c: got valid %b expected 0", outValid); else passCnt++;
    endtask

    task automatic test_bubble();
        drive(1'b1, 160'h5A, 7'h7F, 1'b1); step();
        checkCnt++; if (outCtrl !== 7'h7F) $display("FAIL bubble_live: got %h expected 7f", outCtrl); else passCnt++;
        drive(1'b0, 160'h0, 7'h7F, 1'b1); step();
        checkCnt++; if (outValid !== 1'b0 || outCtrl !== 7'h0)
            $display("FAIL bubble_mask: got v%b ctrl%h expected 0/00", outValid, outCtrl); else passCnt++;
    endtask

    task automatic test_random();
        int budget;
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                  7'($urandom()), $urandom_range(0, 3) != 0);
            step();
            checkCnt++;
            if (count !== 2'(exp_q.size()))
                $display("FAIL rand_count_%0d: got %0d expected %0d", i, count, exp_q.size());
            else passCnt++;
        end
        drive(1'b0, 160'h0, 7'h0, 1'b1);
        budget = 0;
        while (exp_q.size() != 0 && budget < 10) begin
            step();
            budget++;
        end
        checkCnt++; if (exp_q.size() != 0 || outValid !== 1'b0)
            $display("FAIL rand_drain: got %0d left valid %b expected 0/0", exp_q.size(), outValid); else passCnt++;
    endtask

    task automatic test_skid0();
        inValid0 = 1'b1; inData0 = 160'hA0; inCtrl0 = 7'h0C; outReady0 = 1'b0;
        #1;
        checkCnt++; if (inReady0 !== 1'b1) $display("FAIL s0_empty_ready: got %b expected 1", inReady0); else passCnt++;
        @(posedge clk); @(negedge clk);
        checkCnt++; if (outValid0 !== 1'b1 || outData0 !== 160'hA0 || count0 !== 2'd1)
            $display("FAIL s0_load: got v%b d%h c%0d expected v1 a0 c1", outValid0, outData0, count0); else passCnt++;
        inData0 = 160'hB0; inCtrl0 = 7'h30;
        #1;
        checkCnt++; if (inReady0 !== 1'b0) $display("FAIL s0_stall_ready: got %b expected 0", inReady0); else passCnt++;
        outReady0 = 1'b1;
        #1;
        checkCnt++; if (inReady0 !== 1'b1) $display("FAIL s0_comb_ready: got %b expected 1", inReady0); else passCnt++;
        @(posedge clk); @(negedge clk);
        checkCnt++; if (outValid0 !== 1'b1 || outData0 !== 160'hB0 || outCtrl0 !== 7'h30 || count0 !== 2'd1)
            $display("FAIL s0_pass: got v%b d%h ctrl%h c%0d expected v1 b0 30 c1", outValid0, outData0, outCtrl0, count0); else passCnt++;
        inValid0 = 1'b0; inCtrl0 = 7'h7F;
        @(posedge clk); @(negedge clk);
        checkCnt++; if (outValid0 !== 1'b0 || outCtrl0 !== 7'h0 || count0 !== 2'd0)
            $display("FAIL s0_drain: got v%b ctrl%h c%0d expected 0/00/0", outValid0, outCtrl0, count0); else passCnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush();
        test_bubble();
        test_random();
        test_skid0();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
